// File: rtl/sign_unit_pipe.sv
// -----------------------------------------------------------------------------
// sign_unit_pipe
//
// Two-stage elastic sign-operation unit. Each transaction applies one of four
// two's-complement operations to an operand: pass, negate, absolute value or
// negative absolute value. Results that cannot be represented in WIDTH bits
// raise out_ovfl and are either wrapped (MIN) or clamped (MAX). A saturating
// counter tallies delivered overflowed results.
//
// Parameters:
//   WIDTH      operand/result width, two's complement, >= 2
//   SATURATE   0 = overflowed result is MIN (wrapped), 1 = clamp to MAX
//   CNT_WIDTH  width of the overflow event counter
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    producer has an operand
//   in_ready    unit accepts the operand this cycle
//   in_data     operand
//   in_mode     00 pass, 01 negate, 10 abs, 11 nabs
//   out_valid   result present
//   out_ready   consumer takes the result this cycle
//   out_data    result
//   out_ovfl    result was not representable
//   clr_count   synchronous clear of ovfl_count (beats a same-cycle increment)
//   ovfl_count  saturating count of delivered overflowed results
// -----------------------------------------------------------------------------
module sign_unit_pipe #(
   parameter int WIDTH     = 8,
   parameter int SATURATE  = 0,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_ovfl,
   input  logic                 clr_count,
   output logic [CNT_WIDTH-1:0] ovfl_count
);

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_NABS = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

   logic                 r_s1Valid;
   logic [WIDTH-1:0]     r_s1Data;
   mode_e                r_s1Mode;
   logic                 r_outValid;
   logic [WIDTH-1:0]     r_outData;
   logic                 r_outOvfl;
   logic [CNT_WIDTH-1:0] r_count;

   logic                 w_stall;
   logic [WIDTH-1:0]     w_neg;
   logic                 w_isMin;
   logic                 w_sign;
   logic [WIDTH-1:0]     w_result;
   logic                 w_ovfl;
   logic                 w_countInc;

   // The whole pipeline freezes whenever a presented result is not taken;
   // the producer sees this directly as in_ready.
   always_comb begin
      w_stall    = r_outValid & ~out_ready;
      w_countInc = r_outValid & out_ready & r_outOvfl;
   end

   // Stage-2 arithmetic on the stage-1 operand. Only MIN can overflow, and
   // only for negate and abs; nabs of MIN is MIN itself. The two's-complement
   // negation of MIN already wraps to MIN, so only the clamping variant needs
   // an explicit substitution.
   always_comb begin
      w_neg    = ~r_s1Data + WIDTH'(1);
      w_isMin  = (r_s1Data == MIN_VAL);
      w_sign   = r_s1Data[WIDTH-1];
      w_result = r_s1Data;
      w_ovfl   = 1'b0;
      case (r_s1Mode)
         MODE_PASS: begin
            w_result = r_s1Data;
         end
         MODE_NEG: begin
            w_result = w_neg;
            w_ovfl   = w_isMin;
         end
         MODE_ABS: begin
            w_result = w_sign ? w_neg : r_s1Data;
            w_ovfl   = w_isMin;
         end
         MODE_NABS: begin
            w_result = w_sign ? r_s1Data : w_neg;
         end
         default: begin
            w_result = r_s1Data;
         end
      endcase
      if (w_ovfl) begin
         w_result = (SATURATE != 0) ? MAX_VAL : MIN_VAL;
      end
   end

   // Pipeline registers. Both stages advance together when not stalled.
   // Bubbles travel through unchanged; the result registers are only
   // reloaded by a real transaction so they keep their last value otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid  <= 1'b0;
         r_s1Data   <= '0;
         r_s1Mode   <= MODE_PASS;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outOvfl  <= 1'b0;
      end else if (!w_stall) begin
         r_s1Valid  <= in_valid;
         r_s1Data   <= in_data;
         r_s1Mode   <= mode_e'(in_mode);
         r_outValid <= r_s1Valid;
         if (r_s1Valid) begin
            r_outData <= w_result;
            r_outOvfl <= w_ovfl;
         end
      end
   end

   // Overflow event counter: counts overflowed results actually handed to
   // the consumer, sticks at all-ones, and a clear wins over an increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr_count) begin
         r_count <= '0;
      end else if (w_countInc && (r_count != {CNT_WIDTH{1'b1}})) begin
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      in_ready   = ~w_stall;
      out_valid  = r_outValid;
      out_data   = r_outData;
      out_ovfl   = r_outOvfl;
      ovfl_count = r_count;
   end

endmodule

// File: tb/tb_sign_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_sign_unit_pipe
//
// Drives two instances of sign_unit_pipe with identical inputs: one wrapping
// with a 2-bit counter, one clamping with an 8-bit counter. Accepted operands
// are queued by an input monitor; an output monitor predicts when each result
// must appear (two cycles plus any stall cycles), what it must be, and what
// both overflow counters must read, comparing every cycle.
// -----------------------------------------------------------------------------
module tb_sign_unit_pipe;

   localparam int W    = 8;
   localparam int CW0  = 2;
   localparam int CW1  = 8;
   localparam int CAP0 = (1 << CW0) - 1;
   localparam int CAP1 = (1 << CW1) - 1;
   localparam int MAXV = (1 << (W-1)) - 1;
   localparam logic [W-1:0] MAXW = W'(MAXV);
   localparam logic [W-1:0] MINW = W'(MAXV + 1);

   typedef struct {
      logic [W-1:0] x;
      logic [1:0]   mode;
      int           cyc;
      int           stl;
   } item_t;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic [W-1:0]   in_data;
   logic [1:0]     in_mode;
   logic           out_ready;
   logic           clr_count;

   logic           in_ready0, in_ready1;
   logic           out_valid0, out_valid1;
   logic [W-1:0]   out_data0, out_data1;
   logic           out_ovfl0, out_ovfl1;
   logic [CW0-1:0] cnt0;
   logic [CW1-1:0] cnt1;

   item_t q[$];
   int    checkCount = 0;
   int    passCount  = 0;
   int    cycle      = 0;
   int    stallCnt   = 0;
   bit    stallNext  = 0;
   bit    started    = 0;
   bit    randMode   = 0;
   int    expCnt0    = 0;
   int    expCnt1    = 0;

   sign_unit_pipe #(.WIDTH(W), .SATURATE(0), .CNT_WIDTH(CW0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid0),
      .out_ready(out_ready), .out_data(out_data0), .out_ovfl(out_ovfl0),
      .clr_count(clr_count), .ovfl_count(cnt0)
   );

   sign_unit_pipe #(.WIDTH(W), .SATURATE(1), .CNT_WIDTH(CW1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .out_ovfl(out_ovfl1),
      .clr_count(clr_count), .ovfl_count(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed integer arithmetic, overflow means "above MAX".
   function automatic logic [W:0] refModel(input logic [W-1:0] x,
                                           input logic [1:0] mode,
                                           input bit sat);
      int xi;
      int r;
      xi = int'($signed(x));
      case (mode)
         2'd0:    r = xi;
         2'd1:    r = -xi;
         2'd2:    r = (xi < 0) ? -xi : xi;
         default: r = (xi < 0) ? xi : -xi;
      endcase
      if (r > MAXV) return {1'b1, (sat ? MAXW : MINW)};
      return {1'b0, r[W-1:0]};
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (randMode) begin
         out_ready = ($urandom_range(0, 3) != 0);
         clr_count = ($urandom_range(0, 15) == 0);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] x, input logic [1:0] mode);
      bit done;
      done     = 0;
      in_valid = 1'b1;
      in_data  = x;
      in_mode  = mode;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = in_ready0;
         stepCycle();
      end
      in_valid = 1'b0;
      if (!done) checkOutput("accept timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) stepCycle();
   endtask

   always @(posedge clk) begin
      cycle    <= cycle + 1;
      stallCnt <= stallCnt + (stallNext ? 1 : 0);
   end

   // Input side of the scoreboard: record every accepted operand.
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready0) begin
         q.push_back('{x: in_data, mode: in_mode, cyc: cycle, stl: stallCnt});
      end
   end

   // Output side: predict presence, contents and counters every cycle.
   always @(negedge clk) begin : monitor
      bit           expValid;
      logic [W:0]   e0;
      logic [W:0]   e1;
      expValid = 0;
      e0       = '0;
      e1       = '0;
      if (q.size() > 0) begin
         expValid = ((cycle - q[0].cyc - (stallCnt - q[0].stl)) == 2);
         e0 = refModel(q[0].x, q[0].mode, 1'b0);
         e1 = refModel(q[0].x, q[0].mode, 1'b1);
      end
      if (started) begin
         checkOutput("out_valid wrap", int'(out_valid0), int'(expValid));
         checkOutput("out_valid sat", int'(out_valid1), int'(expValid));
         checkOutput("in_ready wrap", int'(in_ready0), int'(!(expValid && !out_ready)));
         checkOutput("in_ready sat", int'(in_ready1), int'(!(expValid && !out_ready)));
         if (expValid) begin
            checkOutput("out_data wrap", int'(out_data0), int'(e0[W-1:0]));
            checkOutput("out_ovfl wrap", int'(out_ovfl0), int'(e0[W]));
            checkOutput("out_data sat", int'(out_data1), int'(e1[W-1:0]));
            checkOutput("out_ovfl sat", int'(out_ovfl1), int'(e1[W]));
         end
         checkOutput("ovfl_count wrap", int'(cnt0), expCnt0);
         checkOutput("ovfl_count sat", int'(cnt1), expCnt1);
      end
      if (rst) begin
         q.delete();
         expCnt0   = 0;
         expCnt1   = 0;
         stallNext = 0;
         started   = 1;
      end else begin
         stallNext = expValid && !out_ready;
         if (clr_count) begin
            expCnt0 = 0;
            expCnt1 = 0;
         end else if (expValid && out_ready && e0[W]) begin
            if (expCnt0 < CAP0) expCnt0++;
            if (expCnt1 < CAP1) expCnt1++;
         end
         if (expValid && out_ready) void'(q.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0] x;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'b00;
      out_ready = 1'b1;
      clr_count = 1'b0;
      repeat (3) stepCycle();
      rst = 1'b0;
      idle(2);

      $display("[TB] directed: negate, abs, nabs, pass");
      applyStimulus(8'h05, 2'b01);
      applyStimulus(8'h00, 2'b01);
      applyStimulus(8'h7F, 2'b01);
      applyStimulus(8'h80, 2'b01);
      applyStimulus(8'h80, 2'b10);
      applyStimulus(8'hFB, 2'b10);
      applyStimulus(8'h05, 2'b10);
      applyStimulus(8'h05, 2'b11);
      applyStimulus(8'h80, 2'b11);
      applyStimulus(8'h00, 2'b11);
      applyStimulus(8'h80, 2'b00);
      applyStimulus(8'h7F, 2'b10);
      idle(4);

      $display("[TB] directed: backpressure");
      applyStimulus(8'h01, 2'b01);
      applyStimulus(8'h02, 2'b01);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h03;
      in_mode   = 2'b01;
      repeat (3) stepCycle();
      out_ready = 1'b1;
      applyStimulus(8'h03, 2'b01);
      idle(4);

      $display("[TB] directed: counter saturation and clear");
      clr_count = 1'b1;
      stepCycle();
      clr_count = 1'b0;
      repeat (5) applyStimulus(8'h80, 2'b01);
      idle(3);
      applyStimulus(8'h80, 2'b01);
      stepCycle();
      clr_count = 1'b1;
      stepCycle();
      clr_count = 1'b0;
      idle(3);

      $display("[TB] directed: reset mid-operation");
      applyStimulus(8'h80, 2'b01);
      out_ready = 1'b0;
      applyStimulus(8'h7F, 2'b01);
      rst = 1'b1;
      stepCycle();
      rst       = 1'b0;
      out_ready = 1'b1;
      idle(5);

      $display("[TB] random phase");
      randMode = 1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         case ($urandom_range(0, 7))
            0:       x = MINW;
            1:       x = MAXW;
            2:       x = '0;
            3:       x = '1;
            default: x = W'($urandom);
         endcase
         applyStimulus(x, 2'($urandom_range(0, 3)));
      end
      randMode  = 0;
      out_ready = 1'b1;
      clr_count = 1'b0;
      idle(10);
      checkOutput("scoreboard drained", q.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
